// File: rtl/if_prefetch.sv
// Instruction-fetch prefetch buffer.
// Issues one outstanding fetch at a time into a circular {pc, inst} FIFO.
// A redirect flushes the FIFO. A response that is still in flight when the
// redirect arrives is drained in DROP and then discarded.
module if_prefetch #(
    parameter int unsigned        ADDR_W   = 32,
    parameter int unsigned        INST_W   = 32,
    parameter int unsigned        DEPTH    = 4,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       redirect_i,
    input  logic [ADDR_W-1:0]          redirect_pc_i,
    output logic                       mem_req_o,
    output logic [ADDR_W-1:0]          mem_addr_o,
    input  logic                       mem_valid_i,
    input  logic [INST_W-1:0]          mem_inst_i,
    output logic                       inst_valid_o,
    output logic [INST_W-1:0]          inst_o,
    output logic [ADDR_W-1:0]          pc_o,
    input  logic                       id_ready_i,
    output logic                       halt_req_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;

    logic [ADDR_W-1:0]  pc_mem   [DEPTH];
    logic [INST_W-1:0]  inst_mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   count_after;

    logic [ADDR_W-1:0]  fetch_pc;
    logic [ADDR_W-1:0]  fetch_pc_next;
    logic [ADDR_W-1:0]  mem_addr;
    logic [ADDR_W-1:0]  mem_addr_next;

    logic               push;
    logic               pop;
    logic               room;

    // Head of the FIFO is visible directly from storage
    assign inst_valid_o = (count != '0);
    assign halt_req_o   = (count == '0);
    assign inst_o       = inst_mem[rd_ptr];
    assign pc_o         = pc_mem[rd_ptr];
    assign count_o      = count;
    assign mem_req_o    = (state != IDLE);
    assign mem_addr_o   = mem_addr;

    // A redirect suppresses the pop so the flush wins over decode.
    assign pop = (count != '0) && id_ready_i && !redirect_i;

    // Occupancy after this cycle's push, used to decide whether to keep fetching.
    assign count_after = count + CNT_W'(1) - CNT_W'(pop);
    assign room        = (count_after < CNT_W'(DEPTH));

    // Next-state, fetch PC and request address selection
    always_comb begin
        state_next    = state;
        fetch_pc_next = fetch_pc;
        mem_addr_next = mem_addr;
        push          = 1'b0;
        case (state)
            IDLE: begin
                if (redirect_i) begin
                    fetch_pc_next = redirect_pc_i;
                end else if (count < CNT_W'(DEPTH)) begin
                    state_next    = BUSY;
                    mem_addr_next = fetch_pc;
                end
            end
            BUSY: begin
                if (redirect_i) begin
                    fetch_pc_next = redirect_pc_i;
                    state_next    = mem_valid_i ? IDLE : DROP;
                end else if (mem_valid_i) begin
                    push          = 1'b1;
                    fetch_pc_next = fetch_pc + ADDR_W'(3'd4);
                    if (room) begin
                        mem_addr_next = fetch_pc + ADDR_W'(3'd4);
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            DROP: begin
                if (redirect_i) begin
                    fetch_pc_next = redirect_pc_i;
                end
                if (mem_valid_i) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // FSM state, fetch PC and held request address registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            mem_addr <= '0;
        end else begin
            state    <= state_next;
            fetch_pc <= fetch_pc_next;
            mem_addr <= mem_addr_next;
        end
    end

    // FIFO pointers and occupancy; a redirect empties the FIFO by aligning the pointers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (redirect_i) begin
            rd_ptr <= wr_ptr;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // FIFO storage; cleared on reset so the head reads zero while empty after reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                pc_mem[i]   <= '0;
                inst_mem[i] <= '0;
            end
        end else if (push) begin
            pc_mem[wr_ptr]   <= mem_addr;
            inst_mem[wr_ptr] <= mem_inst_i;
        end
    end

endmodule

// File: tb/tb_if_prefetch.sv
// Directed testbench for if_prefetch (default parameters, DEPTH=4).
module tb_if_prefetch;

    logic        clk;
    logic        rst;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_valid_i;
    logic [31:0] mem_inst_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] pc_o;
    logic        id_ready_i;
    logic        halt_req_o;
    logic [2:0]  count_o;

    int n_checks;
    int n_pass;
    int age;
    int lat;
    bit auto_resp;

    if_prefetch dut (
        .clk           (clk),
        .rst           (rst),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .mem_req_o     (mem_req_o),
        .mem_addr_o    (mem_addr_o),
        .mem_valid_i   (mem_valid_i),
        .mem_inst_i    (mem_inst_i),
        .inst_valid_o  (inst_valid_o),
        .inst_o        (inst_o),
        .pc_o          (pc_o),
        .id_ready_i    (id_ready_i),
        .halt_req_o    (halt_req_o),
        .count_o       (count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock; the memory model answers 'lat' cycles after a request appears.
    task automatic step();
        logic req_b;
        logic val_b;
        req_b = mem_req_o;
        val_b = mem_valid_i;
        @(posedge clk);
        #1;
        if (!req_b || val_b) age = 0;
        else age = age + 1;
        if (auto_resp) begin
            mem_valid_i = mem_req_o && (age == lat);
            mem_inst_i  = 32'hA000_0000 | mem_addr_o;
        end
    endtask

    task automatic apply_reset();
        rst           = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;
        mem_valid_i   = 1'b0;
        mem_inst_i    = '0;
        id_ready_i    = 1'b0;
        auto_resp     = 1'b0;
        age           = 0;
        step();
        step();
        rst = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        lat      = 1;

        // Reset values
        apply_reset();
        rst = 1'b0;
        #1;
        check("rst_inst_valid", inst_valid_o, 0);
        check("rst_halt",       halt_req_o,   1);
        check("rst_count",      count_o,      0);
        check("rst_inst",       inst_o,       0);
        check("rst_pc",         pc_o,         0);
        check("rst_req",        mem_req_o,    0);
        check("rst_addr",       mem_addr_o,   0);
        rst = 1'b1;

        // Streaming fetch with decode always ready
        auto_resp  = 1'b1;
        lat        = 1;
        id_ready_i = 1'b1;
        step();
        check("s1_req0",  mem_req_o,  1);
        check("s1_addr0", mem_addr_o, 0);
        check("s1_halt0", halt_req_o, 1);
        step();
        for (int k = 0; k < 3; k++) begin
            step();
            check("s1_valid", inst_valid_o, 1);
            check("s1_pc",    pc_o,         4 * k);
            check("s1_inst",  inst_o,       32'hA000_0000 | (4 * k));
            check("s1_halt",  halt_req_o,   0);
            check("s1_next",  mem_addr_o,   4 * k + 4);
            step();
            check("s1_popped", count_o, 0);
        end

        // Fill to full with decode stalled, then release one slot
        apply_reset();
        auto_resp = 1'b1;
        lat       = 1;
        repeat (7) step();
        check("s2_cnt3",   count_o,    3);
        check("s2_addrC",  mem_addr_o, 32'hC);
        check("s2_req3",   mem_req_o,  1);
        repeat (2) step();
        check("s2_full",   count_o,    4);
        check("s2_reqoff", mem_req_o,  0);
        check("s2_head",   pc_o,       0);
        step();
        check("s2_hold",   count_o,    4);
        check("s2_idle",   mem_req_o,  0);
        id_ready_i = 1'b1;
        step();
        id_ready_i = 1'b0;
        check("s2_pop_cnt", count_o, 3);
        check("s2_pop_pc",  pc_o,    4);
        step();
        check("s2_reissue", mem_req_o,  1);
        check("s2_addr10",  mem_addr_o, 32'h10);
        repeat (2) step();
        check("s2_refull", count_o,   4);
        check("s2_reidle", mem_req_o, 0);

        // Wrapped pointers, continuous push and pop at constant occupancy
        lat        = 0;
        id_ready_i = 1'b1;
        step();
        check("s3_cnt_a", count_o, 3);
        check("s3_pc_a",  pc_o,    8);
        step();
        check("s3_cnt_b", count_o,    2);
        check("s3_pc_b",  pc_o,       32'hC);
        check("s3_req_b", mem_req_o,  1);
        check("s3_addr",  mem_addr_o, 32'h14);
        for (int j = 1; j < 6; j++) begin
            step();
            check("s3_cnt",  count_o, 2);
            check("s3_pc",   pc_o,    32'hC + 4 * j);
            check("s3_inst", inst_o,  32'hA000_000C + 4 * j);
        end

        // Redirect while a request is in flight; late response is dropped
        apply_reset();
        step();
        check("s4_busy", mem_req_o, 1);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h100;
        step();
        redirect_i = 1'b0;
        check("s4_drop_req",  mem_req_o,  1);
        check("s4_drop_addr", mem_addr_o, 0);
        check("s4_drop_cnt",  count_o,    0);
        step();
        check("s4_drop_hold", mem_req_o, 1);
        step();
        mem_valid_i = 1'b1;
        mem_inst_i  = 32'hDEAD_BEEF;
        step();
        mem_valid_i = 1'b0;
        check("s4_idle_req", mem_req_o,    0);
        check("s4_no_push",  inst_valid_o, 0);
        check("s4_cnt",      count_o,      0);
        step();
        check("s4_new_req",  mem_req_o,  1);
        check("s4_new_addr", mem_addr_o, 32'h100);

        // Redirect coincident with response and pop at count 2
        apply_reset();
        auto_resp = 1'b1;
        lat       = 1;
        repeat (5) step();
        check("s5_cnt2", count_o, 2);
        step();
        check("s5_resp", mem_valid_i, 1);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h100;
        id_ready_i    = 1'b1;
        step();
        redirect_i = 1'b0;
        id_ready_i = 1'b0;
        check("s5_flush", count_o,      0);
        check("s5_valid", inst_valid_o, 0);
        check("s5_halt",  halt_req_o,   1);
        check("s5_idle",  mem_req_o,    0);
        step();
        check("s5_req",  mem_req_o,  1);
        check("s5_addr", mem_addr_o, 32'h100);
        repeat (2) step();
        check("s5_cnt1", count_o, 1);
        check("s5_pc",   pc_o,    32'h100);

        // Reset in the middle of a request; stray response afterwards
        apply_reset();
        auto_resp  = 1'b1;
        lat        = 1;
        id_ready_i = 1'b1;
        repeat (5) step();
        check("s6_busy_addr", mem_addr_o, 8);
        auto_resp   = 1'b0;
        mem_valid_i = 1'b0;
        #1;
        rst = 1'b0;
        #1;
        check("s6_req_off", mem_req_o,    0);
        check("s6_addr",    mem_addr_o,   0);
        check("s6_cnt",     count_o,      0);
        check("s6_valid",   inst_valid_o, 0);
        mem_valid_i = 1'b1;
        mem_inst_i  = 32'h1234_5678;
        step();
        rst = 1'b1;
        step();
        mem_valid_i = 1'b0;
        check("s6_stray_cnt", count_o,    0);
        check("s6_restart",   mem_req_o,  1);
        check("s6_reset_pc",  mem_addr_o, 0);
        step();
        check("s6_still_empty", inst_valid_o, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
